// File: rtl/vga_shadow_pkg.sv
// vga_shadow_pkg: shared state enum, defaults and address fold helper.
// Build option VGA_SHADOW_DIFF_EN enables per-word change tracking.
package vga_shadow_pkg;

    localparam int DEF_NUM_CH = 3;
    localparam int DEF_WORD_W = 32;
    localparam int DEF_ROWS   = 46;
    localparam int DEF_COLS   = 2;
    localparam int DEF_ADDR_W = 32;
    localparam int MAX_COLS   = 16;

    typedef enum logic {
        ST_CLEAR,
        ST_IDLE
    } state_t;

    typedef struct packed {
        logic        ok;
        logic [15:0] row;
        logic [7:0]  col;
    } rc_t;

    // One compare per column band instead of a divider.
    function automatic rc_t addr_to_row_col(
        input logic [63:0] addr,
        input int          rows,
        input int          cols
    );
        rc_t        rc;
        logic [63:0] lo;
        logic [63:0] hi;
        rc = '0;
        for (int c = 0; c < MAX_COLS; c++) begin
            lo = 64'(c * rows);
            hi = 64'((c + 1) * rows);
            if (c < cols && addr >= lo && addr < hi) begin
                rc.ok  = 1'b1;
                rc.row = 16'(addr - lo);
                rc.col = 8'(c);
            end
        end
        return rc;
    endfunction

endpackage

// File: rtl/vga_shadow_bank.sv
// vga_shadow_bank: one channel of ROWS x COLS words with registered row read.
// Build option VGA_SHADOW_DIFF_EN adds per-word changed flags.
module vga_shadow_bank
    import vga_shadow_pkg::*;
#(
    parameter int WORD_W = DEF_WORD_W,
    parameter int ROWS   = DEF_ROWS,
    parameter int COLS   = DEF_COLS,
    localparam int ROW_W = $clog2(ROWS),
    localparam int COL_W = (COLS > 1) ? $clog2(COLS) : 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   clr_en,
    input  logic [ROW_W-1:0]       clr_row,
    input  logic                   wr_en,
    input  logic [ROW_W-1:0]       wr_row,
    input  logic [COL_W-1:0]       wr_col,
    input  logic [WORD_W-1:0]      wr_data,
    input  logic                   rd_en,
    input  logic [ROW_W-1:0]       rd_row,
`ifdef VGA_SHADOW_DIFF_EN
    input  logic                   frame_start,
    output logic [COLS-1:0]        rd_changed,
`endif
    output logic [COLS*WORD_W-1:0] rd_data
);

    logic [WORD_W-1:0] mem [ROWS][COLS];
    logic              rd_hit;

    assign rd_hit = 32'(rd_row) < ROWS;

    always_ff @(posedge clk) begin
        if (clr_en) begin
            for (int c = 0; c < COLS; c++) begin
                mem[clr_row][c] <= '0;
            end
        end else if (wr_en) begin
            mem[wr_row][wr_col] <= wr_data;
        end
    end

    // Column 0 lands in the most significant word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data <= '0;
        end else if (rd_en) begin
            for (int c = 0; c < COLS; c++) begin
                rd_data[(COLS-1-c)*WORD_W +: WORD_W] <=
                    rd_hit ? mem[rd_row][c] : '0;
            end
        end
    end

`ifdef VGA_SHADOW_DIFF_EN
    logic [COLS-1:0] chg [ROWS];

    always_ff @(posedge clk) begin
        if (frame_start) begin
            for (int r = 0; r < ROWS; r++) begin
                chg[r] <= '0;
            end
        end
        if (clr_en) begin
            chg[clr_row] <= '0;
        end else if (wr_en && wr_data != mem[wr_row][wr_col]) begin
            chg[wr_row][wr_col] <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_changed <= '0;
        end else if (rd_en) begin
            for (int c = 0; c < COLS; c++) begin
                rd_changed[COLS-1-c] <= rd_hit ? chg[rd_row][c] : 1'b0;
            end
        end
    end
`endif

endmodule

// File: rtl/vga_shadow_ram.sv
// vga_shadow_ram: multi-channel shadow memory feeding the VGA text renderer.
// Build option VGA_SHADOW_DIFF_EN adds frame_start and rd_changed.
module vga_shadow_ram
    import vga_shadow_pkg::*;
#(
    parameter int NUM_CH = DEF_NUM_CH,
    parameter int WORD_W = DEF_WORD_W,
    parameter int ROWS   = DEF_ROWS,
    parameter int COLS   = DEF_COLS,
    parameter int ADDR_W = DEF_ADDR_W,
    localparam int ROW_W = $clog2(ROWS)
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          clear_req,
    output logic                          clear_busy,
    input  logic [NUM_CH-1:0]             wr_valid,
    output logic [NUM_CH-1:0]             wr_ready,
    input  logic [NUM_CH*ADDR_W-1:0]      wr_addr,
    input  logic [NUM_CH*WORD_W-1:0]      wr_data,
    input  logic                          rd_en,
    input  logic [ROW_W-1:0]              rd_row,
    output logic [NUM_CH*COLS*WORD_W-1:0] rd_data,
`ifdef VGA_SHADOW_DIFF_EN
    input  logic                          frame_start,
    output logic [NUM_CH*COLS-1:0]        rd_changed,
`endif
    output logic                          rd_valid,
    output logic                          addr_err
);

    localparam int COL_W = (COLS > 1) ? $clog2(COLS) : 1;

    state_t           state;
    state_t           state_n;
    logic [ROW_W-1:0] row_cnt;
    logic [ROW_W-1:0] row_n;
    logic [NUM_CH-1:0] wr_fire;
    logic [NUM_CH-1:0] wr_bad;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_CLEAR;
            row_cnt <= '0;
        end else begin
            state   <= state_n;
            row_cnt <= row_n;
        end
    end

    always_comb begin
        state_n = state;
        row_n   = row_cnt;
        unique case (state)
            ST_CLEAR: begin
                if (clear_req) begin
                    row_n = '0;
                end else if (row_cnt == ROW_W'(ROWS - 1)) begin
                    state_n = ST_IDLE;
                    row_n   = '0;
                end else begin
                    row_n = row_cnt + 1'b1;
                end
            end
            ST_IDLE: begin
                if (clear_req) begin
                    state_n = ST_CLEAR;
                    row_n   = '0;
                end
            end
            default: begin
                state_n = ST_CLEAR;
                row_n   = '0;
            end
        endcase
    end

    assign clear_busy = (state == ST_CLEAR);
    assign wr_ready   = {NUM_CH{!clear_busy}};

    for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
        rc_t  rc;
        logic hit;

        assign rc = addr_to_row_col(
            64'(wr_addr[ch*ADDR_W +: ADDR_W]), ROWS, COLS);
        assign hit = rc.ok && rc.row < 16'(ROWS) && rc.col < 8'(COLS);
        assign wr_fire[ch] = wr_valid[ch] && wr_ready[ch];
        assign wr_bad[ch]  = wr_fire[ch] && !hit;

        vga_shadow_bank #(
            .WORD_W (WORD_W),
            .ROWS   (ROWS),
            .COLS   (COLS)
        ) u_bank (
            .clk         (clk),
            .rst_n       (rst_n),
            .clr_en      (clear_busy),
            .clr_row     (row_cnt),
            .wr_en       (wr_fire[ch] && hit),
            .wr_row      (rc.row[ROW_W-1:0]),
            .wr_col      (rc.col[COL_W-1:0]),
            .wr_data     (wr_data[ch*WORD_W +: WORD_W]),
            .rd_en       (rd_en),
            .rd_row      (rd_row),
`ifdef VGA_SHADOW_DIFF_EN
            .frame_start (frame_start),
            .rd_changed  (rd_changed[ch*COLS +: COLS]),
`endif
            .rd_data     (rd_data[ch*COLS*WORD_W +: COLS*WORD_W])
        );
    end

    // A clear request wipes the error along with the memories.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_err <= 1'b0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= rd_en;
            if (clear_req) begin
                addr_err <= 1'b0;
            end else if (|wr_bad) begin
                addr_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_vga_shadow_ram.sv
// tb_vga_shadow_ram: directed self-checking bench for vga_shadow_ram.
// Define VGA_SHADOW_DIFF_EN to also exercise change tracking.
module tb_vga_shadow_ram;

    localparam int NCH = 3;
    localparam int WW  = 32;
    localparam int NR  = 46;
    localparam int NC  = 2;
    localparam int AW  = 32;
    localparam int RW  = 6;
    localparam int DW  = NCH * NC * WW;

    logic              clk;
    logic              rst_n;
    logic              clear_req;
    logic              clear_busy;
    logic [NCH-1:0]    wr_valid;
    logic [NCH-1:0]    wr_ready;
    logic [NCH*AW-1:0] wr_addr;
    logic [NCH*WW-1:0] wr_data;
    logic              rd_en;
    logic [RW-1:0]     rd_row;
    logic [DW-1:0]     rd_data;
    logic              rd_valid;
    logic              addr_err;
`ifdef VGA_SHADOW_DIFF_EN
    logic              frame_start;
    logic [NCH*NC-1:0] rd_changed;
`endif

    int n_tests;
    int n_fail;

    vga_shadow_ram dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .clear_req   (clear_req),
        .clear_busy  (clear_busy),
        .wr_valid    (wr_valid),
        .wr_ready    (wr_ready),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .rd_en       (rd_en),
        .rd_row      (rd_row),
        .rd_data     (rd_data),
`ifdef VGA_SHADOW_DIFF_EN
        .frame_start (frame_start),
        .rd_changed  (rd_changed),
`endif
        .rd_valid    (rd_valid),
        .addr_err    (addr_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic rd(input int row, output logic [DW-1:0] d,
                      output logic v);
        rd_en  = 1'b1;
        rd_row = RW'(row);
        @(negedge clk);
        rd_en = 1'b0;
        d = rd_data;
        v = rd_valid;
    endtask

    task automatic wr1(input int ch, input logic [31:0] a,
                       input logic [31:0] d);
        wr_valid = '0;
        wr_valid[ch] = 1'b1;
        wr_addr[ch*AW +: AW] = a;
        wr_data[ch*WW +: WW] = d;
        @(negedge clk);
        wr_valid = '0;
    endtask

    task automatic test_reset;
        int cnt;
        int rdy_bad;
        logic [DW-1:0] d;
        logic v;
        n_tests++;
        if (clear_busy !== 1'b1 || wr_ready !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_busy: busy=%b ready=%b want 1/000",
                     clear_busy, wr_ready);
        end
        n_tests++;
        if (rd_valid !== 1'b0 || rd_data !== '0 || addr_err !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_outs: valid=%b data=%h err=%b want 0",
                     rd_valid, rd_data, addr_err);
        end
        rst_n = 1'b1;
        cnt = 0;
        rdy_bad = 0;
        while (clear_busy && cnt < 200) begin
            if (wr_ready !== 3'b000) rdy_bad++;
            cnt++;
            @(negedge clk);
        end
        n_tests++;
        if (cnt !== NR) begin
            n_fail++;
            $display("FAIL reset_sweep_len: got %0d want %0d", cnt, NR);
        end
        n_tests++;
        if (rdy_bad !== 0) begin
            n_fail++;
            $display("FAIL reset_ready_low: %0d bad cycles want 0", rdy_bad);
        end
        for (int r = 0; r < NR; r++) begin
            rd(r, d, v);
            n_tests++;
            if (d !== '0 || v !== 1'b1) begin
                n_fail++;
                $display("FAIL reset_row%0d: data=%h valid=%b want 0/1",
                         r, d, v);
            end
        end
    endtask

    task automatic test_write;
        logic [DW-1:0] exp;
        logic [DW-1:0] held;
        exp = {32'h0, 32'h12345678, 64'h0, 32'hDEADBEEF, 32'h0};
        n_tests++;
        if (wr_ready !== 3'b111) begin
            n_fail++;
            $display("FAIL idle_ready: got %b want 111", wr_ready);
        end
        wr_valid = 3'b101;
        wr_addr[0 +: AW]    = 32'd5;
        wr_data[0 +: WW]    = 32'hDEADBEEF;
        wr_addr[2*AW +: AW] = 32'd51;
        wr_data[2*WW +: WW] = 32'h12345678;
        @(negedge clk);
        wr_valid = '0;
        rd_en  = 1'b1;
        rd_row = 6'd5;
        n_tests++;
        if (rd_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL valid_idle: got %b want 0", rd_valid);
        end
        @(negedge clk);
        rd_en = 1'b0;
        held = rd_data;
        n_tests++;
        if (rd_valid !== 1'b1 || rd_data !== exp) begin
            n_fail++;
            $display("FAIL write_row5: data=%h valid=%b want %h/1",
                     rd_data, rd_valid, exp);
        end
        @(negedge clk);
        n_tests++;
        if (rd_valid !== 1'b0 || rd_data !== held) begin
            n_fail++;
            $display("FAIL read_hold: data=%h valid=%b want %h/0",
                     rd_data, rd_valid, held);
        end
    endtask

    task automatic test_addr_err;
        logic [DW-1:0] d;
        logic [DW-1:0] exp5;
        logic [DW-1:0] exp45;
        logic v;
        int cnt;
        exp5  = {32'h0, 32'h12345678, 64'h0, 32'hDEADBEEF, 32'h0};
        exp45 = {64'h0, 32'h0, 32'hCAFEF00D, 64'h0};
        n_tests++;
        if (addr_err !== 1'b0) begin
            n_fail++;
            $display("FAIL err_before: got %b want 0", addr_err);
        end
        wr1(1, 32'd92, 32'hFFFFFFFF);
        n_tests++;
        if (addr_err !== 1'b1) begin
            n_fail++;
            $display("FAIL err_set: got %b want 1", addr_err);
        end
        repeat (4) @(negedge clk);
        n_tests++;
        if (addr_err !== 1'b1) begin
            n_fail++;
            $display("FAIL err_sticky: got %b want 1", addr_err);
        end
        rd(0, d, v);
        n_tests++;
        if (d !== '0) begin
            n_fail++;
            $display("FAIL oor_row0: got %h want 0", d);
        end
        rd(5, d, v);
        n_tests++;
        if (d !== exp5) begin
            n_fail++;
            $display("FAIL oor_row5: got %h want %h", d, exp5);
        end
        wr1(1, 32'd91, 32'hCAFEF00D);
        rd(45, d, v);
        n_tests++;
        if (d !== exp45) begin
            n_fail++;
            $display("FAIL last_addr: got %h want %h", d, exp45);
        end
        rd(46, d, v);
        n_tests++;
        if (d !== '0 || v !== 1'b1) begin
            n_fail++;
            $display("FAIL row46: data=%h valid=%b want 0/1", d, v);
        end
        rd(63, d, v);
        n_tests++;
        if (d !== '0 || v !== 1'b1) begin
            n_fail++;
            $display("FAIL row63: data=%h valid=%b want 0/1", d, v);
        end
        clear_req = 1'b1;
        @(negedge clk);
        clear_req = 1'b0;
        n_tests++;
        if (addr_err !== 1'b0 || clear_busy !== 1'b1) begin
            n_fail++;
            $display("FAIL err_clear: err=%b busy=%b want 0/1",
                     addr_err, clear_busy);
        end
        cnt = 0;
        while (clear_busy && cnt < 200) begin
            cnt++;
            @(negedge clk);
        end
        n_tests++;
        if (cnt !== NR) begin
            n_fail++;
            $display("FAIL clear_len: got %0d want %0d", cnt, NR);
        end
        rd(5, d, v);
        n_tests++;
        if (d !== '0) begin
            n_fail++;
            $display("FAIL cleared_row5: got %h want 0", d);
        end
        rd(45, d, v);
        n_tests++;
        if (d !== '0) begin
            n_fail++;
            $display("FAIL cleared_row45: got %h want 0", d);
        end
    endtask

    task automatic test_clear_restart;
        logic [DW-1:0] d;
        logic v;
        int cnt;
        int rdy_bad;
        wr1(0, 32'd10, 32'h00000055);
        rd(10, d, v);
        n_tests++;
        if (d[63:32] !== 32'h55) begin
            n_fail++;
            $display("FAIL pre_clear: got %h want 55", d[63:32]);
        end
        clear_req = 1'b1;
        wr_valid = 3'b001;
        wr_addr[0 +: AW] = 32'd10;
        wr_data[0 +: WW] = 32'h00000077;
        @(negedge clk);
        clear_req = 1'b0;
        rdy_bad = 0;
        // row 0 is being swept now; 20 cycles later it is row 20
        repeat (20) begin
            if (wr_ready !== 3'b000) rdy_bad++;
            @(negedge clk);
        end
        clear_req = 1'b1;
        @(negedge clk);
        clear_req = 1'b0;
        cnt = 0;
        while (clear_busy && cnt < 300) begin
            clear_req = (cnt == 30);
            if (wr_ready !== 3'b000) rdy_bad++;
            cnt++;
            @(negedge clk);
        end
        clear_req = 1'b0;
        wr_valid = '0;
        n_tests++;
        if (cnt !== 31 + NR) begin
            n_fail++;
            $display("FAIL restart_len: got %0d want %0d", cnt, 31 + NR);
        end
        n_tests++;
        if (rdy_bad !== 0) begin
            n_fail++;
            $display("FAIL restart_ready: %0d bad cycles want 0", rdy_bad);
        end
        rd(10, d, v);
        n_tests++;
        if (d !== '0) begin
            n_fail++;
            $display("FAIL restart_row10: got %h want 0", d);
        end
    endtask

    task automatic test_rbw;
        logic [DW-1:0] d;
        logic v;
        wr_valid = 3'b001;
        wr_addr[0 +: AW] = 32'd7;
        wr_data[0 +: WW] = 32'hA5A5A5A5;
        rd_en  = 1'b1;
        rd_row = 6'd7;
        @(negedge clk);
        wr_valid = '0;
        rd_en = 1'b0;
        n_tests++;
        if (rd_data[63:32] !== 32'h0 || rd_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL rbw_old: got %h/%b want 0/1",
                     rd_data[63:32], rd_valid);
        end
        rd(7, d, v);
        n_tests++;
        if (d[63:32] !== 32'hA5A5A5A5) begin
            n_fail++;
            $display("FAIL rbw_new: got %h want a5a5a5a5", d[63:32]);
        end
    endtask

`ifdef VGA_SHADOW_DIFF_EN
    task automatic test_diff;
        logic [DW-1:0] d;
        logic v;
        frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
        wr1(0, 32'd3, 32'h1);
        rd(3, d, v);
        n_tests++;
        if (rd_changed !== 6'b000010 || d[63:32] !== 32'h1) begin
            n_fail++;
            $display("FAIL diff_set: chg=%b data=%h want 000010/1",
                     rd_changed, d[63:32]);
        end
        frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
        rd(3, d, v);
        n_tests++;
        if (rd_changed !== 6'b000000) begin
            n_fail++;
            $display("FAIL diff_frame: chg=%b want 000000", rd_changed);
        end
        wr1(0, 32'd3, 32'h1);
        rd(3, d, v);
        n_tests++;
        if (rd_changed !== 6'b000000) begin
            n_fail++;
            $display("FAIL diff_same: chg=%b want 000000", rd_changed);
        end
    endtask
`endif

    initial begin
        n_tests   = 0;
        n_fail    = 0;
        rst_n     = 1'b0;
        clear_req = 1'b0;
        wr_valid  = '0;
        wr_addr   = '0;
        wr_data   = '0;
        rd_en     = 1'b0;
        rd_row    = '0;
`ifdef VGA_SHADOW_DIFF_EN
        frame_start = 1'b0;
`endif
        repeat (3) @(negedge clk);
        test_reset;
        test_write;
        test_addr_err;
        test_clear_restart;
        test_rbw;
`ifdef VGA_SHADOW_DIFF_EN
        test_diff;
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
